// File: rtl/carpma_sirlayici_if.sv
// Request/result channel between the core and the arithmetic sequencer.
// The core side drives the request and accepts results; the sequencer side mirrors it.
interface carpma_sirlayici_if #(
    parameter int unsigned VERI_GENISLIGI = 32
);
    logic                      istek_gecerli;
    logic                      istek_hazir;
    logic [2:0]                funct3;
    logic [VERI_GENISLIGI-1:0] islenen_a;
    logic [VERI_GENISLIGI-1:0] islenen_b;
    logic                      sec;
    logic                      iptal;
    logic                      sonuc_gecerli;
    logic                      sonuc_hazir;
    logic [VERI_GENISLIGI-1:0] sonuc;
    logic                      hata;
    logic                      mesgul;

    modport master (
        output istek_gecerli, funct3, islenen_a, islenen_b, sec, iptal, sonuc_hazir,
        input  istek_hazir, sonuc_gecerli, sonuc, hata, mesgul
    );

    modport slave (
        input  istek_gecerli, funct3, islenen_a, islenen_b, sec, iptal, sonuc_hazir,
        output istek_hazir, sonuc_gecerli, sonuc, hata, mesgul
    );
endinterface

// File: rtl/carpma_sirlayici.sv
// Multi-cycle sequencer for KAREAL TOPLA, CARP CIKAR and BITSAY using one shared
// shift-add multiplier and a bit-serial population counter.
module carpma_sirlayici #(
    parameter int unsigned VERI_GENISLIGI  = 32,
    parameter int unsigned SAYAC_GENISLIGI = 6
) (
    input logic                  saat,
    input logic                  reset,
    carpma_sirlayici_if.slave    bus
);
    localparam logic [2:0] F3_KAREAL = 3'b000;
    localparam logic [2:0] F3_CARP   = 3'b001;
    localparam logic [2:0] F3_BITSAY = 3'b010;
    localparam logic [SAYAC_GENISLIGI-1:0] SON_SAYI = SAYAC_GENISLIGI'(VERI_GENISLIGI - 1);

    typedef enum logic [2:0] {BOSTA, CARP1, CARP2, BITSAY, SON, SONUC} durum_t;

    durum_t durum, sonraki;

    logic [VERI_GENISLIGI-1:0]  reg_a, reg_b;
    logic [VERI_GENISLIGI-1:0]  carpilan, carpan, acc;
    logic [VERI_GENISLIGI-1:0]  sonuc_r;
    logic [2:0]                 islem;
    logic                       secim;
    logic                       hata_r;
    logic [SAYAC_GENISLIGI-1:0] sayac;
    logic                       son_tur;

    assign son_tur = (sayac == SON_SAYI);

    always_ff @(posedge saat or negedge reset) begin
        if (!reset) durum <= BOSTA;
        else        durum <= sonraki;
    end

    always_comb begin
        sonraki = durum;
        if (bus.iptal) begin
            sonraki = BOSTA;
        end else begin
            case (durum)
                BOSTA: begin
                    if (bus.istek_gecerli) begin
                        case (bus.funct3)
                            F3_KAREAL, F3_CARP: sonraki = CARP1;
                            F3_BITSAY:          sonraki = BITSAY;
                            default:            sonraki = SON;
                        endcase
                    end
                end
                CARP1:   if (son_tur) sonraki = (islem == F3_KAREAL) ? CARP2 : SON;
                CARP2:   if (son_tur) sonraki = SON;
                BITSAY:  if (son_tur) sonraki = SON;
                SON:     sonraki = SONUC;
                SONUC:   if (bus.sonuc_hazir) sonraki = BOSTA;
                default: sonraki = BOSTA;
            endcase
        end
    end

    always_comb begin
        bus.istek_hazir   = (durum == BOSTA);
        bus.sonuc_gecerli = (durum == SONUC);
        bus.mesgul        = (durum != BOSTA);
        bus.sonuc         = sonuc_r;
        bus.hata          = hata_r;
    end

    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            reg_a    <= '0;
            reg_b    <= '0;
            carpilan <= '0;
            carpan   <= '0;
            acc      <= '0;
            sonuc_r  <= '0;
            islem    <= '0;
            secim    <= 1'b0;
            hata_r   <= 1'b0;
            sayac    <= '0;
        end else if (bus.iptal) begin
            sonuc_r <= '0;
            hata_r  <= 1'b0;
            sayac   <= '0;
        end else begin
            case (durum)
                BOSTA: begin
                    if (bus.istek_gecerli) begin
                        reg_a    <= bus.islenen_a;
                        reg_b    <= bus.islenen_b;
                        islem    <= bus.funct3;
                        secim    <= bus.sec;
                        carpilan <= bus.islenen_a;
                        // BITSAY also shifts through carpan, so only CARP CIKAR loads b
                        carpan   <= (bus.funct3 == F3_CARP) ? bus.islenen_b : bus.islenen_a;
                        acc      <= '0;
                        sayac    <= '0;
                        hata_r   <= 1'b0;
                    end
                end
                CARP1, CARP2: begin
                    if (carpan[0]) acc <= acc + carpilan;
                    carpilan <= carpilan << 1;
                    carpan   <= carpan >> 1;
                    sayac    <= son_tur ? '0 : sayac + 1'b1;
                    if (son_tur && durum == CARP1) begin
                        carpilan <= reg_b;
                        carpan   <= reg_b;
                    end
                end
                BITSAY: begin
                    acc    <= acc + VERI_GENISLIGI'(carpan[0] == secim);
                    carpan <= carpan >> 1;
                    sayac  <= son_tur ? '0 : sayac + 1'b1;
                end
                SON: begin
                    case (islem)
                        F3_KAREAL: begin sonuc_r <= acc;         hata_r <= 1'b0; end
                        F3_CARP:   begin sonuc_r <= acc - reg_a; hata_r <= 1'b0; end
                        F3_BITSAY: begin sonuc_r <= acc;         hata_r <= 1'b0; end
                        default:   begin sonuc_r <= '0;          hata_r <= 1'b1; end
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_carpma_sirlayici.sv
// Directed bench for carpma_sirlayici: latency, results, backpressure, abort and reset.
module tb_carpma_sirlayici;
    logic saat;
    logic reset;
    int   total;
    int   bad;

    carpma_sirlayici_if #(.VERI_GENISLIGI(32)) bus ();

    carpma_sirlayici #(.VERI_GENISLIGI(32), .SAYAC_GENISLIGI(6)) dut (
        .saat  (saat),
        .reset (reset),
        .bus   (bus)
    );

    initial saat = 1'b0;
    always #5 saat = ~saat;

    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic s);
        @(negedge saat);
        bus.istek_gecerli = 1'b1;
        bus.funct3        = f3;
        bus.islenen_a     = a;
        bus.islenen_b     = b;
        bus.sec           = s;
        @(posedge saat);
        #1;
        bus.istek_gecerli = 1'b0;
        bus.islenen_a     = 32'hDEAD_BEEF;
        bus.islenen_b     = 32'hCAFE_F00D;
    endtask

    task automatic wait_result(output int edges);
        edges = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge saat);
            #1;
            if (bus.sonuc_gecerli) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        total++; if (bus.istek_hazir !== 1'b1) begin bad++; $display("FAIL reset_istek_hazir got=%b want=1", bus.istek_hazir); end
        total++; if (bus.sonuc_gecerli !== 1'b0) begin bad++; $display("FAIL reset_sonuc_gecerli got=%b want=0", bus.sonuc_gecerli); end
        total++; if (bus.sonuc !== 32'd0) begin bad++; $display("FAIL reset_sonuc got=%0h want=0", bus.sonuc); end
        total++; if (bus.hata !== 1'b0) begin bad++; $display("FAIL reset_hata got=%b want=0", bus.hata); end
        total++; if (bus.mesgul !== 1'b0) begin bad++; $display("FAIL reset_mesgul got=%b want=0", bus.mesgul); end
    endtask

    task automatic test_kareal(input string tag);
        int edges;
        bus.sonuc_hazir = 1'b1;
        send(3'b000, 32'd3, 32'd4, 1'b0);
        total++; if (bus.mesgul !== 1'b1) begin bad++; $display("FAIL %s_mesgul got=%b want=1", tag, bus.mesgul); end
        wait_result(edges);
        total++; if (edges !== 65) begin bad++; $display("FAIL %s_latency got=%0d want=65", tag, edges); end
        total++; if (bus.sonuc !== 32'd25) begin bad++; $display("FAIL %s_sonuc got=%0d want=25", tag, bus.sonuc); end
        total++; if (bus.hata !== 1'b0) begin bad++; $display("FAIL %s_hata got=%b want=0", tag, bus.hata); end
        @(posedge saat); #1;
        total++; if (bus.sonuc_gecerli !== 1'b0) begin bad++; $display("FAIL %s_one_cycle got=%b want=0", tag, bus.sonuc_gecerli); end
        total++; if (bus.istek_hazir !== 1'b1) begin bad++; $display("FAIL %s_idle got=%b want=1", tag, bus.istek_hazir); end
    endtask

    task automatic test_carp_cikar();
        int edges;
        bus.sonuc_hazir = 1'b1;
        send(3'b001, 32'd7, 32'd5, 1'b0);
        wait_result(edges);
        total++; if (edges !== 33) begin bad++; $display("FAIL carp_latency got=%0d want=33", edges); end
        total++; if (bus.sonuc !== 32'd28) begin bad++; $display("FAIL carp_sonuc got=%0d want=28", bus.sonuc); end
        @(posedge saat); #1;
        send(3'b001, 32'hFFFF_FFFF, 32'd2, 1'b0);
        wait_result(edges);
        total++; if (edges !== 33) begin bad++; $display("FAIL carp_wrap_latency got=%0d want=33", edges); end
        total++; if (bus.sonuc !== 32'hFFFF_FFFF) begin bad++; $display("FAIL carp_wrap_sonuc got=%0h want=ffffffff", bus.sonuc); end
        @(posedge saat); #1;
    endtask

    task automatic test_bitsay();
        int edges;
        logic [31:0] av [3] = '{32'hF0F0_000F, 32'hF0F0_000F, 32'h0};
        logic        sv [3] = '{1'b1, 1'b0, 1'b0};
        logic [31:0] ex [3] = '{32'd12, 32'd20, 32'd32};
        bus.sonuc_hazir = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(3'b010, av[i], 32'h5555_5555, sv[i]);
            wait_result(edges);
            total++; if (edges !== 33) begin bad++; $display("FAIL bitsay%0d_latency got=%0d want=33", i, edges); end
            total++; if (bus.sonuc !== ex[i]) begin bad++; $display("FAIL bitsay%0d_sonuc got=%0d want=%0d", i, bus.sonuc, ex[i]); end
            @(posedge saat); #1;
        end
    endtask

    task automatic test_backpressure();
        int edges;
        bus.sonuc_hazir = 1'b0;
        send(3'b001, 32'd7, 32'd5, 1'b0);
        wait_result(edges);
        total++; if (edges !== 33) begin bad++; $display("FAIL bp_latency got=%0d want=33", edges); end
        for (int i = 0; i < 10; i++) begin
            @(posedge saat); #1;
            total++;
            if (bus.sonuc !== 32'd28 || bus.sonuc_gecerli !== 1'b1 || bus.istek_hazir !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d got sonuc=%0d v=%b rdy=%b want 28/1/0", i, bus.sonuc, bus.sonuc_gecerli, bus.istek_hazir);
            end
        end
        @(negedge saat);
        bus.sonuc_hazir = 1'b1;
        @(posedge saat); #1;
        total++; if (bus.sonuc_gecerli !== 1'b0) begin bad++; $display("FAIL bp_release_v got=%b want=0", bus.sonuc_gecerli); end
        total++; if (bus.istek_hazir !== 1'b1) begin bad++; $display("FAIL bp_release_rdy got=%b want=1", bus.istek_hazir); end
    endtask

    task automatic test_abort_reset();
        int seen;
        bus.sonuc_hazir = 1'b1;
        send(3'b000, 32'd3, 32'd4, 1'b0);
        repeat (20) @(posedge saat);
        #1;
        bus.iptal = 1'b1;
        @(posedge saat); #1;
        bus.iptal = 1'b0;
        total++; if (bus.mesgul !== 1'b0 || bus.istek_hazir !== 1'b1) begin bad++; $display("FAIL abort_idle got mesgul=%b rdy=%b want 0/1", bus.mesgul, bus.istek_hazir); end
        seen = 0;
        repeat (70) begin
            @(posedge saat); #1;
            if (bus.sonuc_gecerli) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_result got=%0d want=0", seen); end

        send(3'b010, 32'h1234_5678, 32'd0, 1'b1);
        repeat (10) @(posedge saat);
        #1;
        reset = 1'b0;
        #1;
        total++;
        if (bus.mesgul !== 1'b0 || bus.istek_hazir !== 1'b1 || bus.sonuc !== 32'd0 || bus.sonuc_gecerli !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got mesgul=%b rdy=%b sonuc=%0h v=%b want 0/1/0/0", bus.mesgul, bus.istek_hazir, bus.sonuc, bus.sonuc_gecerli);
        end
        @(negedge saat);
        reset = 1'b1;
        test_kareal("kareal_after_reset");
    endtask

    task automatic test_unsupported_and_hold();
        int edges;
        bus.sonuc_hazir = 1'b1;
        send(3'b111, 32'd9, 32'd9, 1'b0);
        wait_result(edges);
        total++; if (edges !== 1) begin bad++; $display("FAIL bad_f3_latency got=%0d want=1", edges); end
        total++; if (bus.sonuc !== 32'd0 || bus.hata !== 1'b1) begin bad++; $display("FAIL bad_f3_result got sonuc=%0h hata=%b want 0/1", bus.sonuc, bus.hata); end
        @(posedge saat); #1;

        send(3'b001, 32'd7, 32'd5, 1'b0);
        repeat (3) @(posedge saat);
        bus.islenen_a = 32'h0000_1234;
        bus.islenen_b = 32'h0000_0099;
        wait_result(edges);
        total++; if (edges !== 30) begin bad++; $display("FAIL hold_latency got=%0d want=30", edges); end
        total++; if (bus.sonuc !== 32'd28 || bus.hata !== 1'b0) begin bad++; $display("FAIL hold_sonuc got=%0d hata=%b want 28/0", bus.sonuc, bus.hata); end
        @(posedge saat); #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.istek_gecerli = 1'b0;
        bus.funct3        = 3'b000;
        bus.islenen_a     = '0;
        bus.islenen_b     = '0;
        bus.sec           = 1'b0;
        bus.iptal         = 1'b0;
        bus.sonuc_hazir   = 1'b0;
        repeat (2) @(posedge saat);
        #1;
        test_reset();
        @(negedge saat);
        reset = 1'b1;
        test_kareal("kareal");
        test_carp_cikar();
        test_bitsay();
        test_backpressure();
        test_abort_reset();
        test_unsupported_and_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
